// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, instruction fields,
// ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_t;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  function automatic logic funct_known(input logic [5:0] funct);
    case (funct)
      FnAdd, FnSub, FnAnd, FnOr, FnNor, FnSlt: funct_known = 1'b1;
      default:                                 funct_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: ALUOp from the FSM plus the R-type funct field select ALUControl.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (alu_op)
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct)
          FnAdd:   alu_control = AluAdd;
          FnSub:   alu_control = AluSub;
          FnAnd:   alu_control = AluAnd;
          FnOr:    alu_control = AluOr;
          FnNor:   alu_control = AluNor;
          FnSlt:   alu_control = AluSlt;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multicycle MIPS datapath. Moore-decoded controls, with the
// memory-completion strobes qualified by mem_ready.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       retire,
  output logic       illegal
);

  state_t     state;
  logic [1:0] alu_op;
  logic [3:0] alu_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= state_t'(RESET_STATE);
    end else begin
      case (state)
        StFetch:  if (mem_ready) state <= StDecode;
        StDecode: begin
          case (Opcode)
            OpLw, OpSw: state <= StMemAdr;
            OpR:        state <= funct_known(Funct) ? StExec : StFetch;
            OpBeq:      state <= StBranch;
            OpAddi:     state <= StAddiEx;
            OpJ:        state <= StJump;
            default:    state <= StFetch;
          endcase
        end
        StMemAdr: state <= (Opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) state <= StMemWb;
        StMemWr:  if (mem_ready) state <= StFetch;
        StExec:   state <= StAluWb;
        StAddiEx: state <= StAddiWb;
        default:  state <= StFetch;  // single-cycle tails and unencoded values
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PcSrcAlu;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SrcBReg;
    alu_op   = AluOpAdd;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state)
      StFetch: begin
        mem_req = 1'b1;
        ALUSrcB = SrcBFour;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh;
        case (Opcode)
          OpLw, OpSw, OpBeq, OpAddi, OpJ: illegal = 1'b0;
          OpR:     illegal = !funct_known(Funct);
          default: illegal = 1'b1;
        endcase
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
      end
      StMemRd: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpFunct;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpSub;
        PCSrc   = PcSrcAluOut;
        PCWrite = Zero;
        retire  = 1'b1;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StJump: begin
        PCSrc   = PcSrcJump;
        PCWrite = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
    // While reset is held nothing may write; only the pending fetch request stays visible.
    if (!rst_n) begin
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      retire   = 1'b0;
      illegal  = 1'b0;
      mem_req  = 1'b1;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct      (Funct),
    .alu_control(alu_ctrl)
  );

  assign ALUControl = rst_n ? alu_ctrl : 4'b0000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a per-instruction step table predicts every
// cycle's controls, with memory stalls and reset-abandon scenarios.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode, Funct;
  logic       Zero, mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic       retire, illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [3:0] ALUControl;
  logic [20:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int KR = 0, KLw = 1, KSw = 2, KBeq = 3, KAddi = 4, KJ = 5, KIll = 6;
  // Enable-type outputs are always checked; mux fields only where a value is defined.
  localparam logic [20:0] EnMask  = 21'h1B200C;
  localparam logic [20:0] RstOnly = 21'h100000;

  always #5 clk = ~clk;

  multicycle_controller u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .retire    (retire),
    .illegal   (illegal)
  );

  // [20]mem_req [19]MemWrite [18]IorD [17]IRWrite [16]PCWrite [15:14]PCSrc [13]RegWrite
  // [12]RegDst [11]MemtoReg [10]ALUSrcA [9:8]ALUSrcB [7:4]ALUControl [3]retire [2]illegal
  assign obs = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUControl, retire, illegal, 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic fn_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return fn_ok(fn) ? KR : KIll;
      6'b100011: return KLw;
      6'b101011: return KSw;
      6'b000100: return KBeq;
      6'b001000: return KAddi;
      6'b000010: return KJ;
      default:   return KIll;
    endcase
  endfunction

  function automatic int base_len(input int kind);
    case (kind)
      KLw:       return 5;
      KR, KSw, KAddi: return 4;
      KBeq, KJ:  return 3;
      default:   return 2;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic is_mem_step(input int kind, input int k);
    return (k == 0) || ((kind == KLw || kind == KSw) && k == 3);
  endfunction

  // Expected controls for step k of an instruction of the given kind.
  function automatic void exp_step(input int kind, input int k, input logic mr, input logic z,
                                   input logic [5:0] fn, output logic [20:0] e,
                                   output logic [20:0] m);
    e = '0;
    m = EnMask;
    if (k == 0) begin
      e[20] = 1'b1; e[17] = mr; e[16] = mr; e[9:8] = 2'b01; e[7:4] = 4'b0010;
      m[18] = 1'b1; m[15:14] = 2'b11; m[10] = 1'b1; m[9:8] = 2'b11; m[7:4] = 4'hF;
    end else if (k == 1) begin
      e[9:8] = 2'b11; e[7:4] = 4'b0010; e[2] = (kind == KIll);
      m[10] = 1'b1; m[9:8] = 2'b11; m[7:4] = 4'hF;
    end else begin
      case (kind)
        KR: if (k == 2) begin
          e[10] = 1'b1; e[7:4] = alu_of(fn);
          m[10] = 1'b1; m[9:8] = 2'b11; m[7:4] = 4'hF;
        end else begin
          e[13] = 1'b1; e[12] = 1'b1; e[3] = 1'b1; m[12] = 1'b1; m[11] = 1'b1;
        end
        KLw, KSw: if (k == 2) begin
          e[10] = 1'b1; e[9:8] = 2'b10; e[7:4] = 4'b0010;
          m[10] = 1'b1; m[9:8] = 2'b11; m[7:4] = 4'hF;
        end else if (k == 3 && kind == KLw) begin
          e[20] = 1'b1; e[18] = 1'b1; m[18] = 1'b1;
        end else if (k == 3) begin
          e[20] = 1'b1; e[19] = 1'b1; e[18] = 1'b1; e[3] = mr; m[18] = 1'b1;
        end else begin
          e[13] = 1'b1; e[11] = 1'b1; e[3] = 1'b1; m[12] = 1'b1; m[11] = 1'b1;
        end
        KBeq: begin
          e[10] = 1'b1; e[7:4] = 4'b0110; e[15:14] = 2'b01; e[16] = z; e[3] = 1'b1;
          m[10] = 1'b1; m[9:8] = 2'b11; m[7:4] = 4'hF; m[15:14] = 2'b11;
        end
        KAddi: if (k == 2) begin
          e[10] = 1'b1; e[9:8] = 2'b10; e[7:4] = 4'b0010;
          m[10] = 1'b1; m[9:8] = 2'b11; m[7:4] = 4'hF;
        end else begin
          e[13] = 1'b1; e[3] = 1'b1; m[12] = 1'b1; m[11] = 1'b1;
        end
        default: begin
          e[15:14] = 2'b10; e[16] = 1'b1; e[3] = 1'b1; m[15:14] = 2'b11;
        end
      endcase
    end
  endfunction

  // Entered and left at #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fst,
                           input int mst, input logic z);
    int kind = kind_of(op, fn);
    int len = base_len(kind);
    int k = 0, waited = 0, cyc = 0, ret_at = 0, limit;
    int total = len + fst + ((kind == KLw || kind == KSw) ? mst : 0);
    logic [20:0] e, m;
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    while (k < len) begin
      if (is_mem_step(kind, k)) begin
        limit = (k == 0) ? fst : mst;
        mem_ready = (waited >= limit);
      end else begin
        mem_ready = 1'($urandom);
      end
      @(negedge clk);
      exp_step(kind, k, mem_ready, z, fn, e, m);
      check($sformatf("op%b_k%0d", op, k), 32'(obs & m), 32'(e & m));
      cyc++;
      if ((retire || illegal) && ret_at == 0) ret_at = cyc;
      @(posedge clk);
      #1;
      if (is_mem_step(kind, k) && !mem_ready) waited++;
      else begin
        k++;
        waited = 0;
      end
    end
    check($sformatf("lat_op%b", op), 32'(ret_at), 32'(total));
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                 6'b101010};
    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [20:0] e, m;

    rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b1; Opcode = 6'b000010; Funct = 6'b100000;
    #1;
    check("reset", 32'(obs), 32'(RstOnly));
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);  // R ADD
    run_instr(6'b100011, 6'b000000, 0, 2, 1'b0);  // LW, 2 MEMRD stalls
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);  // BEQ taken
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);  // BEQ not taken
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);  // illegal opcode
    run_instr(6'b000000, 6'b111111, 0, 0, 1'b0);  // illegal funct
    run_instr(6'b000010, 6'b000000, 5, 0, 1'b0);  // 5 FETCH stalls
    run_instr(6'b101011, 6'b000000, 1, 3, 1'b0);  // SW with stalls

    // Reset mid-MEMWR while memory is still busy.
    Opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #2;
    check("memwr_pre", 32'({MemWrite, mem_req}), 32'd3);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_mid", 32'(obs), 32'(RstOnly));
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_step(KJ, 0, 1'b0, 1'b0, 6'b0, e, m);
    check("post_rst", 32'(obs & m), 32'(e & m));

    for (int i = 0; i < 250; i++) begin
      int sel = $urandom_range(0, 7);
      op = (sel < 6) ? ops[sel] : ((sel == 6) ? 6'($urandom) : 6'b000000);
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
